lc3_mem_ctrl: RTL and testbench
===============================

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 bus_in  input  16  datapath bus value; source for MAR and for MDR loads from the bus.
REQ-005 ld_mar  input  1  load MAR from bus_in.
REQ-006 ld_mdr  input  1  load MDR; source selected by mio_en.
REQ-007 mio_en  input  1  with ld_mdr: 1 = memory read into MDR, 0 = MDR <= bus_in.
REQ-008 mem_w_en  input  1  write MDR to M[MAR].
REQ-009 mdr_out  output  16  current MDR contents.
REQ-010 mem_ready  output  1  one-cycle pulse marking completion of a read or write request.
REQ-011 ram_addr  output  16  RAM address.
REQ-012 ram_wdata  output  16  RAM write data.
REQ-013 ram_we  output  1  RAM write strobe.
REQ-014 ram_rdata  input  16  RAM read data, valid one cycle after ram_addr.
REQ-015 kb_data  input  8  keyboard character.
REQ-016 kb_valid  input  1  one-cycle keyboard strobe.
REQ-017 ddr_data  output  8  display character.
REQ-018 ddr_valid  output  1  one-cycle display strobe.
REQ-019 ddr_ready  input  1  display can accept a character.

Function
REQ-020 States SHALL be IDLE, RD_WAIT, WR, WR_IO and DONE; requests are sampled only in IDLE.
REQ-021 In IDLE, ld_mar=1 SHALL load MAR <= bus_in at the clock edge.
REQ-022 In IDLE, ld_mdr=1 with mio_en=0 SHALL load MDR <= bus_in at the clock edge, with no mem_ready pulse.
REQ-023 Read: in IDLE, ld_mdr=1 with mio_en=1 SHALL drive ram_addr=MAR and move to RD_WAIT. In RD_WAIT, MDR captures the read value, then the state moves to DONE. mem_ready=1 in DONE only, which is 2 cycles after the request cycle.
REQ-024 The read value SHALL be selected by MAR:
  - MAR < xFE00: ram_rdata.
  - xFE00 (KBSR): {kb_full,15'b0}.
  - xFE02 (KBDR): {8'b0,kb_char}, and kb_full is cleared.
  - xFE04 (DSR): {ddr_ready,15'b0}.
  - Any other address >= xFE00: x0000.
REQ-025 RAM write: in IDLE, mem_w_en=1 with MAR < xFE00 SHALL go to WR. In WR, ram_we=1, ram_addr=MAR and ram_wdata=MDR, then the state moves to DONE.
REQ-026 Write to xFE06 (DDR) SHALL go to WR_IO.
  - WR_IO waits for ddr_ready=1.
  - In the cycle ddr_ready=1: ddr_valid=1 and ddr_data=MDR[7:0], then the state moves to DONE.
REQ-027 Writes to any other address >= xFE00 SHALL be ignored, and the state still passes through WR to DONE without asserting ram_we.
REQ-028 DONE SHALL last exactly one cycle and then return to IDLE. The requester deasserts its request in the cycle it sees mem_ready.
REQ-029 mem_w_en together with (ld_mdr & mio_en) in IDLE SHALL perform the write only; the read is dropped.
REQ-030 ld_mar together with a read or write request in IDLE SHALL use the old MAR for the access and load the new MAR value.
REQ-031 Outside IDLE, ld_mar and ld_mdr SHALL be ignored.
REQ-032 kb_valid=1 SHALL set kb_char <= kb_data and kb_full <= 1. If kb_full is already 1, the character is overwritten. If kb_valid coincides with the KBDR clear, the new character wins and kb_full=1.
REQ-033 ram_we and ddr_valid SHALL never be 1 outside WR and WR_IO respectively.

Reset
REQ-034 rst=1 SHALL set state=IDLE, MAR=0, MDR=0, kb_char=0 and kb_full=0. During reset, mem_ready=0, ram_we=0 and ddr_valid=0.
REQ-035 Reset mid-transaction, including while waiting in WR_IO, SHALL abort the transaction. No mem_ready, ram_we or ddr_valid is produced for the aborted transaction.

Structure
REQ-036 The shared package lc3_pkg SHALL hold:
  - the state encoding;
  - the constants KBSR=xFE00, KBDR=xFE02, DSR=xFE04, DDR=xFE06 and IO_BASE=xFE00.
REQ-037 One sub-module, lc3_mmio, SHALL hold kb_char and kb_full and the I/O read-mux; the MAR, MDR and FSM stay in lc3_mem_ctrl.

Verification
REQ-038 The bench SHALL cover the following directed scenarios:
  - RAM read: ld_mar with bus_in=x3000; ld_mdr+mio_en with ram_rdata=x1234 -> mem_ready 2 cycles later, mdr_out=x1234.
  - RAM write: MAR=x3001, MDR=xBEEF, mem_w_en -> ram_we=1 for exactly 1 cycle with addr x3001 and data xBEEF, then mem_ready.
  - Keyboard: kb_valid with kb_data=x41, read xFE00 -> x8000. Read xFE02 -> x0041. Read xFE00 again -> x0000.
  - Display: ddr_ready=0, write MDR=x0058 to xFE06 -> hold 5 cycles with no ddr_valid. Raise ddr_ready -> ddr_valid=1 with ddr_data=x58, then mem_ready.
  - Reset in WR_IO: no ddr_valid or mem_ready follows, and all registers are 0.
  - Write/read conflict: mem_w_en with ld_mdr+mio_en in IDLE -> write only; an unused address (xFE08) reads x0000 and writes to it are ignored.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory controller slice.
// Holds the controller state encoding, the memory-mapped I/O register
// addresses and a helper that classifies an address as device space.
package lc3_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR      = 3'd2,
        WR_IO   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [15:0] IO_BASE = 16'hFE00;
    localparam logic [15:0] KBSR    = 16'hFE00;
    localparam logic [15:0] KBDR    = 16'hFE02;
    localparam logic [15:0] DSR     = 16'hFE04;
    localparam logic [15:0] DDR     = 16'hFE06;

    // Everything from IO_BASE upward belongs to devices, never to RAM.
    function automatic logic is_io(input logic [15:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// Bundle of every signal the memory controller exchanges with the CPU
// datapath, the synchronous RAM, the keyboard and the display.
//   slave  : the controller's view (requests/RAM data/devices in, results out)
//   master : the view of whoever drives the controller (CPU, RAM, devices)
interface lc3_mem_ctrl_if;

    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        mem_w_en;
    logic [15:0] mdr_out;
    logic        mem_ready;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [7:0]  kb_data;
    logic        kb_valid;
    logic [7:0]  ddr_data;
    logic        ddr_valid;
    logic        ddr_ready;

    modport slave (
        input  bus_in, ld_mar, ld_mdr, mio_en, mem_w_en,
        input  ram_rdata, kb_data, kb_valid, ddr_ready,
        output mdr_out, mem_ready, ram_addr, ram_wdata, ram_we,
        output ddr_data, ddr_valid
    );

    modport master (
        output bus_in, ld_mar, ld_mdr, mio_en, mem_w_en,
        output ram_rdata, kb_data, kb_valid, ddr_ready,
        input  mdr_out, mem_ready, ram_addr, ram_wdata, ram_we,
        input  ddr_data, ddr_valid
    );

endinterface

// File: rtl/lc3_mmio.sv
// Keyboard register file and read-data selector for the memory controller.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   addr_i        : address of the access being completed
//   kbdr_rd_i     : a read of KBDR is completing this cycle (clears kb_full)
//   ram_rdata_i   : data returned by the RAM
//   kb_data_i     : keyboard character, kb_valid_i its one-cycle strobe
//   ddr_ready_i   : display can accept a character (reported through DSR)
//   rdata_o       : value the MDR should capture for a read of addr_i
module lc3_mmio
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_i,
    input  logic        kbdr_rd_i,
    input  logic [15:0] ram_rdata_i,
    input  logic [7:0]  kb_data_i,
    input  logic        kb_valid_i,
    input  logic        ddr_ready_i,
    output logic [15:0] rdata_o
);

    logic [7:0] kb_char_q, kb_char_d;
    logic       kb_full_q, kb_full_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            kb_char_q <= 8'h00;
            kb_full_q <= 1'b0;
        end else begin
            kb_char_q <= kb_char_d;
            kb_full_q <= kb_full_d;
        end
    end

    // A new keystroke is applied after the KBDR clear so that a character
    // arriving in the same cycle as the read is not lost.
    always_comb begin
        kb_char_d = kb_char_q;
        kb_full_d = kb_full_q;
        if (kbdr_rd_i) begin
            kb_full_d = 1'b0;
        end
        if (kb_valid_i) begin
            kb_char_d = kb_data_i;
            kb_full_d = 1'b1;
        end
    end

    // Unmapped device addresses read as zero rather than leaking RAM data.
    always_comb begin
        rdata_o = 16'h0000;
        if (!is_io(addr_i)) begin
            rdata_o = ram_rdata_i;
        end else begin
            case (addr_i)
                KBSR:    rdata_o = {kb_full_q, 15'b0};
                KBDR:    rdata_o = {8'b0, kb_char_q};
                DSR:     rdata_o = {ddr_ready_i, 15'b0};
                default: rdata_o = 16'h0000;
            endcase
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: owns MAR, MDR and the access FSM, and routes
// accesses either to the synchronous RAM or to the memory-mapped keyboard
// and display.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : lc3_mem_ctrl_if.slave carrying the CPU request/response
//              signals, the RAM port and the keyboard/display signals
module lc3_mem_ctrl
    import lc3_pkg::*;
(
    input logic           clk,
    input logic           rst,
    lc3_mem_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    // Address of the access in flight. MAR may be reloaded in the same
    // cycle a request is accepted, so the access keeps its own copy.
    logic [15:0] acc_q, acc_d;
    logic [15:0] io_rdata;
    logic        kbdr_rd;

    lc3_mmio u_mmio (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (acc_q),
        .kbdr_rd_i   (kbdr_rd),
        .ram_rdata_i (bus.ram_rdata),
        .kb_data_i   (bus.kb_data),
        .kb_valid_i  (bus.kb_valid),
        .ddr_ready_i (bus.ddr_ready),
        .rdata_o     (io_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            acc_q   <= acc_d;
        end
    end

    // Requests are only looked at in IDLE; a write takes priority over a
    // simultaneous memory read, which is simply dropped.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        acc_d   = acc_q;
        kbdr_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_mar) begin
                    mar_d = bus.bus_in;
                end
                if (bus.ld_mdr && !bus.mio_en) begin
                    mdr_d = bus.bus_in;
                end
                if (bus.mem_w_en) begin
                    acc_d   = mar_q;
                    state_d = (mar_q == DDR) ? WR_IO : WR;
                end else if (bus.ld_mdr && bus.mio_en) begin
                    acc_d   = mar_q;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                mdr_d   = io_rdata;
                kbdr_rd = (acc_q == KBDR);
                state_d = DONE;
            end
            WR: begin
                state_d = DONE;
            end
            WR_IO: begin
                if (bus.ddr_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are masked by rst so an aborted transaction emits nothing
    // even in the cycle reset is applied.
    assign bus.mem_ready = (state_q == DONE) && !rst;
    assign bus.ram_we    = (state_q == WR) && !is_io(acc_q) && !rst;
    assign bus.ddr_valid = (state_q == WR_IO) && bus.ddr_ready && !rst;

    // The RAM sees MAR in the request cycle so its data is ready in RD_WAIT.
    assign bus.ram_addr  = (state_q == IDLE) ? mar_q : acc_q;
    assign bus.ram_wdata = mdr_q;
    assign bus.ddr_data  = mdr_q[7:0];
    assign bus.mdr_out   = mdr_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed testbench for lc3_mem_ctrl: RAM read/write, keyboard and
// display registers, reset abort and request conflicts.
module tb_lc3_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lc3_mem_ctrl_if bus ();

    lc3_mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous RAM stand-in: x3000 holds x1234, every other word xDEAD.
    always @(posedge clk) begin
        bus.ram_rdata <= (bus.ram_addr == 16'h3000) ? 16'h1234 : 16'hDEAD;
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive all request inputs for the current IDLE cycle, advance one cycle.
    task automatic applyStimulus(input logic ldMar, input logic ldMdr,
                                 input logic mioEn, input logic [15:0] busIn);
        bus.ld_mar = ldMar;
        bus.ld_mdr = ldMdr;
        bus.mio_en = mioEn;
        bus.bus_in = busIn;
        @(negedge clk);
        bus.ld_mar = 1'b0;
        bus.ld_mdr = 1'b0;
        bus.mio_en = 1'b0;
    endtask

    task automatic clearRequests();
        bus.ld_mar   = 1'b0;
        bus.ld_mdr   = 1'b0;
        bus.mio_en   = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    // Issue a memory read from the current MAR and hold it until mem_ready.
    task automatic memRead(input string tag, input logic [15:0] expData);
        int n = 0;
        bus.ld_mdr = 1'b1;
        bus.mio_en = 1'b1;
        #1;
        while (!bus.mem_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_lat"}, 16'(n), 16'd2);
        checkOutput({tag, "_mdr"}, bus.mdr_out, expData);
        clearRequests();
        @(negedge clk);
    endtask

    // Issue a write to the current MAR, counting ram_we/ddr_valid cycles.
    task automatic memWrite(output int lat, output int weCnt,
                            output int dvCnt, output logic [15:0] weAddr,
                            output logic [15:0] weData);
        lat = 0;
        weCnt = 0;
        dvCnt = 0;
        weAddr = 16'h0000;
        weData = 16'h0000;
        bus.mem_w_en = 1'b1;
        #1;
        while (!bus.mem_ready && lat < 20) begin
            if (bus.ram_we) begin
                weCnt++;
                weAddr = bus.ram_addr;
                weData = bus.ram_wdata;
            end
            if (bus.ddr_valid) dvCnt++;
            @(negedge clk);
            #1;
            lat++;
        end
        if (bus.ram_we) weCnt++;
        if (bus.ddr_valid) dvCnt++;
        clearRequests();
        @(negedge clk);
    endtask

    initial begin
        int          lat, weCnt, dvCnt, bad;
        logic [15:0] weAddr, weData;

        $display("[TB] lc3_mem_ctrl directed test");
        rst           = 1'b1;
        bus.bus_in    = 16'h0000;
        bus.kb_data   = 8'h00;
        bus.kb_valid  = 1'b0;
        bus.ddr_ready = 1'b0;
        clearRequests();

        // Reset: strobes quiet during reset, MAR/MDR zero afterwards.
        @(negedge clk);
        bus.ld_mar = 1'b1;
        bus.bus_in = 16'h7777;
        bus.ddr_ready = 1'b1;
        #1;
        checkOutput("rst_ready", 16'(bus.mem_ready), 16'd0);
        checkOutput("rst_we", 16'(bus.ram_we), 16'd0);
        checkOutput("rst_dvalid", 16'(bus.ddr_valid), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.ld_mar = 1'b0;
        bus.ddr_ready = 1'b0;
        #1;
        checkOutput("rst_mdr", bus.mdr_out, 16'h0000);
        checkOutput("rst_mar", bus.ram_addr, 16'h0000);
        @(negedge clk);

        // RAM read.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h3000);
        #1 checkOutput("rd_addr", bus.ram_addr, 16'h3000);
        memRead("ram_rd", 16'h1234);

        // RAM write.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h3001);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hBEEF);
        #1 checkOutput("ldmdr_bus", bus.mdr_out, 16'hBEEF);
        checkOutput("ldmdr_noready", 16'(bus.mem_ready), 16'd0);
        memWrite(lat, weCnt, dvCnt, weAddr, weData);
        checkOutput("wr_lat", 16'(lat), 16'd2);
        checkOutput("wr_we_cnt", 16'(weCnt), 16'd1);
        checkOutput("wr_addr", weAddr, 16'h3001);
        checkOutput("wr_data", weData, 16'hBEEF);

        // Read with simultaneous MAR load uses the old MAR.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h3000);
        bus.ld_mar = 1'b1;
        bus.bus_in = 16'h4000;
        memRead("rd_oldmar", 16'h1234);
        #1 checkOutput("rd_newmar", bus.ram_addr, 16'h4000);

        // Keyboard.
        bus.kb_data = 8'h41;
        bus.kb_valid = 1'b1;
        @(negedge clk);
        bus.kb_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE00);
        memRead("kbsr_full", 16'h8000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE02);
        memRead("kbdr", 16'h0041);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE00);
        memRead("kbsr_empty", 16'h0000);

        // Display status register.
        bus.ddr_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE04);
        memRead("dsr_ready", 16'h8000);
        bus.ddr_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE04);
        memRead("dsr_busy", 16'h0000);

        // Display write waits for ddr_ready.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE06);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0058);
        bus.mem_w_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.ddr_valid || bus.mem_ready || bus.ram_we) bad++;
            @(negedge clk);
        end
        checkOutput("ddr_hold", 16'(bad), 16'd0);
        bus.ddr_ready = 1'b1;
        #1;
        checkOutput("ddr_valid", 16'(bus.ddr_valid), 16'd1);
        checkOutput("ddr_data", 16'(bus.ddr_data), 16'h0058);
        @(negedge clk);
        #1;
        checkOutput("ddr_ready_pulse", 16'(bus.mem_ready), 16'd1);
        checkOutput("ddr_valid_done", 16'(bus.ddr_valid), 16'd0);
        clearRequests();
        bus.ddr_ready = 1'b0;
        @(negedge clk);
        #1 checkOutput("done_one_cycle", 16'(bus.mem_ready), 16'd0);

        // Reset while waiting in WR_IO.
        bus.kb_data = 8'h5A;
        bus.kb_valid = 1'b1;
        @(negedge clk);
        bus.kb_valid = 1'b0;
        bus.mem_w_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.mem_w_en = 1'b0;
        bus.ddr_ready = 1'b1;
        #1;
        checkOutput("abort_dvalid", 16'(bus.ddr_valid), 16'd0);
        checkOutput("abort_ready", 16'(bus.mem_ready), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.ddr_valid || bus.mem_ready || bus.ram_we) bad++;
            @(negedge clk);
        end
        checkOutput("abort_quiet", 16'(bad), 16'd0);
        #1;
        checkOutput("abort_mdr", bus.mdr_out, 16'h0000);
        checkOutput("abort_mar", bus.ram_addr, 16'h0000);
        bus.ddr_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE00);
        memRead("abort_kbsr", 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE02);
        memRead("abort_kbdr", 16'h0000);

        // Write/read conflict: only the write happens.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h3002);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hCAFE);
        bus.ld_mdr = 1'b1;
        bus.mio_en = 1'b1;
        memWrite(lat, weCnt, dvCnt, weAddr, weData);
        checkOutput("cfl_lat", 16'(lat), 16'd2);
        checkOutput("cfl_we_cnt", 16'(weCnt), 16'd1);
        checkOutput("cfl_addr", weAddr, 16'h3002);
        checkOutput("cfl_mdr", bus.mdr_out, 16'hCAFE);

        // Unused device address.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE08);
        memRead("unused_rd", 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h1111);
        memWrite(lat, weCnt, dvCnt, weAddr, weData);
        checkOutput("unused_lat", 16'(lat), 16'd2);
        checkOutput("unused_we", 16'(weCnt), 16'd0);
        checkOutput("unused_dv", 16'(dvCnt), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
